mem_arbiter: RTL and testbench

Sequences the memory controller and shares it between the instruction-fetch unit and the load/store buffer (LSB). Issues single-cycle start pulses to the controller's IF or LSB port, never both, and spaces them to respect the controller's done/idle handshake. Applies fixed LSB-over-fetch priority with a starvation guard. Squashes rolled-back requests. Data buses (if_data, lsb_r_data, lsb_w_data) wire directly between requesters and controller; this block only steers control.

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_arbiter.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared widths and FSM state encoding for mem_arbiter
package mem_arbiter_pkg;

  localparam int ADDR_WID = 32;
  localparam int STARVE_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GAP      = 3'd1,
    BUSY_IF  = 3'd2,
    BUSY_LD  = 3'd3,
    BUSY_ST  = 3'd4,
    DRAIN_IF = 3'd5
  } state_e;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - steers the memory controller between fetch and LSB requesters
// Single FSM: one access outstanding, LSB priority bounded by a saturating starve counter.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                rollback,
  input  logic                if_req,
  input  logic [ADDR_WID-1:0] if_pc,
  output logic                if_done,
  input  logic                lsb_req,
  input  logic                lsb_wr,
  input  logic [ADDR_WID-1:0] lsb_addr,
  input  logic [2:0]          lsb_len,
  output logic                lsb_done,
  output logic                mc_if_en,
  output logic [ADDR_WID-1:0] mc_if_pc,
  input  logic                mc_if_done,
  output logic                mc_lsb_en,
  output logic                mc_lsb_wr,
  output logic [ADDR_WID-1:0] mc_lsb_addr,
  output logic [2:0]          mc_lsb_len,
  input  logic                mc_lsb_done
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  state_e                state_q, state_d;
  logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;
  logic                  mc_if_en_q, mc_if_en_d;
  logic                  mc_lsb_en_q, mc_lsb_en_d;
  logic                  if_done_q, if_done_d;
  logic                  lsb_done_q, lsb_done_d;
  logic [ADDR_WID-1:0]   mc_if_pc_q, mc_if_pc_d;
  logic                  mc_lsb_wr_q, mc_lsb_wr_d;
  logic [ADDR_WID-1:0]   mc_lsb_addr_q, mc_lsb_addr_d;
  logic [2:0]            mc_lsb_len_q, mc_lsb_len_d;

  always_comb begin
    state_d       = state_q;
    starve_cnt_d  = starve_cnt_q;
    mc_if_en_d    = 1'b0;
    mc_lsb_en_d   = 1'b0;
    if_done_d     = 1'b0;
    lsb_done_d    = 1'b0;
    mc_if_pc_d    = mc_if_pc_q;
    mc_lsb_wr_d   = mc_lsb_wr_q;
    mc_lsb_addr_d = mc_lsb_addr_q;
    mc_lsb_len_d  = mc_lsb_len_q;

    if (rdy) begin
      if (!if_req) starve_cnt_d = '0;

      unique case (state_q)
        IDLE: begin
          if (!rollback) begin
            if (lsb_req && (!if_req || starve_cnt_q < LIMIT)) begin
              mc_lsb_en_d   = 1'b1;
              mc_lsb_wr_d   = lsb_wr;
              mc_lsb_addr_d = lsb_addr;
              mc_lsb_len_d  = lsb_len;
              state_d       = lsb_wr ? BUSY_ST : BUSY_LD;
              if (if_req && starve_cnt_q != '1) starve_cnt_d = starve_cnt_q + STARVE_W'(1);
            end else if (if_req) begin
              mc_if_en_d   = 1'b1;
              mc_if_pc_d   = if_pc;
              state_d      = BUSY_IF;
              starve_cnt_d = '0;
            end
          end
        end
        // Bubble while the controller clears its done.
        GAP: state_d = IDLE;
        BUSY_IF: begin
          if (mc_if_done) begin
            if_done_d = 1'b1;
            state_d   = GAP;
          end else if (rollback) begin
            state_d = DRAIN_IF;
          end
        end
        // The controller always finishes a fetch, so wait it out silently.
        DRAIN_IF: if (mc_if_done) state_d = GAP;
        BUSY_LD: begin
          if (mc_lsb_done) begin
            lsb_done_d = 1'b1;
            state_d    = GAP;
          end else if (rollback) begin
            state_d = GAP;
          end
        end
        BUSY_ST: begin
          if (mc_lsb_done) begin
            lsb_done_d = 1'b1;
            state_d    = GAP;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      starve_cnt_q  <= '0;
      mc_if_en_q    <= 1'b0;
      mc_lsb_en_q   <= 1'b0;
      if_done_q     <= 1'b0;
      lsb_done_q    <= 1'b0;
      mc_if_pc_q    <= '0;
      mc_lsb_wr_q   <= 1'b0;
      mc_lsb_addr_q <= '0;
      mc_lsb_len_q  <= '0;
    end else begin
      state_q       <= state_d;
      starve_cnt_q  <= starve_cnt_d;
      mc_if_en_q    <= mc_if_en_d;
      mc_lsb_en_q   <= mc_lsb_en_d;
      if_done_q     <= if_done_d;
      lsb_done_q    <= lsb_done_d;
      mc_if_pc_q    <= mc_if_pc_d;
      mc_lsb_wr_q   <= mc_lsb_wr_d;
      mc_lsb_addr_q <= mc_lsb_addr_d;
      mc_lsb_len_q  <= mc_lsb_len_d;
    end
  end

  assign mc_if_en    = mc_if_en_q;
  assign mc_lsb_en   = mc_lsb_en_q;
  assign if_done     = if_done_q;
  assign lsb_done    = lsb_done_q;
  assign mc_if_pc    = mc_if_pc_q;
  assign mc_lsb_wr   = mc_lsb_wr_q;
  assign mc_lsb_addr = mc_lsb_addr_q;
  assign mc_lsb_len  = mc_lsb_len_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with an in-bench controller and grant-order model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b0;
  logic        rollback = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_pc = '0;
  logic        if_done;
  logic        lsb_req = 1'b0;
  logic        lsb_wr = 1'b0;
  logic [31:0] lsb_addr = '0;
  logic [2:0]  lsb_len = '0;
  logic        lsb_done;
  logic        mc_if_en;
  logic [31:0] mc_if_pc;
  logic        mc_if_done = 1'b0;
  logic        mc_lsb_en;
  logic        mc_lsb_wr;
  logic [31:0] mc_lsb_addr;
  logic [2:0]  mc_lsb_len;
  logic        mc_lsb_done = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_done_cyc = -100;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .if_req(if_req), .if_pc(if_pc), .if_done(if_done),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_len(lsb_len),
    .lsb_done(lsb_done),
    .mc_if_en(mc_if_en), .mc_if_pc(mc_if_pc), .mc_if_done(mc_if_done),
    .mc_lsb_en(mc_lsb_en), .mc_lsb_wr(mc_lsb_wr), .mc_lsb_addr(mc_lsb_addr),
    .mc_lsb_len(mc_lsb_len), .mc_lsb_done(mc_lsb_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // kind: 0 timeout, 1 fetch, 2 LSB. Also flags stray done pulses while waiting.
  task automatic wait_grant(output int kind);
    bit found;
    bit stray;
    found = 0;
    stray = 0;
    kind  = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (if_done || lsb_done) stray = 1;
      if (mc_if_en || mc_lsb_en) begin
        found = 1;
        kind = mc_lsb_en ? 2 : 1;
        break;
      end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL grant_timeout cyc=%0d no enable within 60 cycles", cyc);
    end else begin
      total++;
      if (mc_if_en && mc_lsb_en) begin
        bad++;
        $display("FAIL en_exclusive if_en=%0b lsb_en=%0b required one only", mc_if_en, mc_lsb_en);
      end
      total++;
      if (cyc - last_done_cyc < 3) begin
        bad++;
        $display("FAIL en_spacing gap=%0d required>=3", cyc - last_done_cyc);
      end
    end
    total++;
    if (stray) begin
      bad++;
      $display("FAIL stray_done got=1 required=0 while waiting for grant");
    end
  endtask

  // Controller model: hold off lat cycles, pulse done, then check the requester-side done.
  task automatic finish_access(input int kind, input int lat, input bit exp_done);
    logic obs;
    if (kind == 0) return;
    for (int i = 0; i < lat; i++) begin
      tick();
      total++;
      if (mc_if_en || mc_lsb_en) begin
        bad++;
        $display("FAIL en_while_busy if_en=%0b lsb_en=%0b required 0", mc_if_en, mc_lsb_en);
      end
    end
    if (kind == 1) mc_if_done = 1'b1;
    else           mc_lsb_done = 1'b1;
    last_done_cyc = cyc;
    tick();
    mc_if_done  = 1'b0;
    mc_lsb_done = 1'b0;
    obs = (kind == 1) ? if_done : lsb_done;
    total++;
    if (obs !== exp_done) begin
      bad++;
      $display("FAIL done_pulse kind=%0d got=%0b required=%0b", kind, obs, exp_done);
    end
    total++;
    if (((kind == 1) ? lsb_done : if_done) !== 1'b0) begin
      bad++;
      $display("FAIL wrong_done kind=%0d if_done=%0b lsb_done=%0b", kind, if_done, lsb_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rdy = 1'b1;
    repeat (3) tick();
    total++;
    if ({mc_if_en, mc_lsb_en, if_done, lsb_done, mc_lsb_wr} !== 5'b0 ||
        mc_if_pc !== 32'h0 || mc_lsb_addr !== 32'h0 || mc_lsb_len !== 3'h0) begin
      bad++;
      $display("FAIL reset_outputs pc=%h addr=%h len=%0d required all 0", mc_if_pc, mc_lsb_addr, mc_lsb_len);
    end
    rst = 1'b1;
    repeat (2) tick();
    total++;
    if (dut.state_q !== IDLE || mc_if_en !== 1'b0 || mc_lsb_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle state=%0d required IDLE", dut.state_q);
    end
  endtask

  task automatic test_lone_fetch();
    int k;
    if_req = 1'b1;
    if_pc  = 32'h100;
    wait_grant(k);
    total++;
    if (k !== 1 || mc_if_pc !== 32'h100) begin
      bad++;
      $display("FAIL lone_grant kind=%0d pc=%h required kind=1 pc=00000100", k, mc_if_pc);
    end
    finish_access(k, 17, 1'b1);
    if_pc = 32'h104;
    wait_grant(k);
    total++;
    if (k !== 1 || mc_if_pc !== 32'h104 || cyc - last_done_cyc !== 3) begin
      bad++;
      $display("FAIL lone_next kind=%0d pc=%h gap=%0d required 1/00000104/3", k, mc_if_pc, cyc - last_done_cyc);
    end
    finish_access(k, 2, 1'b1);
    if_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_simultaneous();
    int k;
    if_req = 1'b1;   if_pc = 32'h200;
    lsb_req = 1'b1;  lsb_wr = 1'b0; lsb_addr = 32'h2000; lsb_len = 3'd4;
    wait_grant(k);
    total++;
    if (k !== 2 || mc_lsb_addr !== 32'h2000 || mc_lsb_len !== 3'd4 || mc_lsb_wr !== 1'b0) begin
      bad++;
      $display("FAIL simul_lsb kind=%0d addr=%h len=%0d wr=%0b required 2/00002000/4/0", k, mc_lsb_addr, mc_lsb_len, mc_lsb_wr);
    end
    finish_access(k, 4, 1'b1);
    lsb_req = 1'b0;
    wait_grant(k);
    total++;
    if (k !== 1 || mc_if_pc !== 32'h200 || cyc - last_done_cyc !== 3) begin
      bad++;
      $display("FAIL simul_fetch kind=%0d pc=%h gap=%0d required 1/00000200/3", k, mc_if_pc, cyc - last_done_cyc);
    end
    finish_access(k, 3, 1'b1);
    if_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_starvation();
    int k;
    int exp_k;
    if_req = 1'b1;  if_pc = 32'h300;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h3000; lsb_len = 3'd2;
    for (int g = 1; g <= LIMIT + 1; g++) begin
      exp_k = (g <= LIMIT) ? 2 : 1;
      wait_grant(k);
      total++;
      if (k !== exp_k) begin
        bad++;
        $display("FAIL starve_grant n=%0d kind=%0d required=%0d", g, k, exp_k);
      end
      if (k == 1) begin
        total++;
        if (dut.starve_cnt_q !== 4'd0) begin
          bad++;
          $display("FAIL starve_cnt got=%0d required=0", dut.starve_cnt_q);
        end
      end
      finish_access(k, 2, 1'b1);
      if (k == 1) if_req = 1'b0;
    end
    if_req  = 1'b0;
    lsb_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_rollback_ld();
    int k;
    int g;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h40; lsb_len = 3'd2;
    wait_grant(k);
    g = cyc;
    tick(); tick();
    rollback = 1'b1;
    lsb_req  = 1'b0;
    tick();
    rollback = 1'b0;
    total++;
    if (dut.state_q !== GAP || lsb_done !== 1'b0) begin
      bad++;
      $display("FAIL rb_ld_state state=%0d lsb_done=%0b required GAP/0", dut.state_q, lsb_done);
    end
    if_req = 1'b1; if_pc = 32'h500;
    wait_grant(k);
    total++;
    if (k !== 1 || cyc - g !== 5) begin
      bad++;
      $display("FAIL rb_ld_next kind=%0d delay=%0d required 1/5", k, cyc - g);
    end
    finish_access(k, 2, 1'b1);
    if_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_rollback_if();
    int k;
    int seen;
    if_req = 1'b1; if_pc = 32'h600;
    wait_grant(k);
    tick(); tick();
    rollback = 1'b1;
    if_req   = 1'b0;
    tick();
    rollback = 1'b0;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h80; lsb_len = 3'd1;
    seen = 0;
    repeat (10) begin
      tick();
      if (mc_if_en || mc_lsb_en || if_done) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL rb_if_drain events=%0d required=0", seen);
    end
    mc_if_done = 1'b1;
    last_done_cyc = cyc;
    tick();
    mc_if_done = 1'b0;
    total++;
    if (if_done !== 1'b0) begin
      bad++;
      $display("FAIL rb_if_done got=%0b required=0", if_done);
    end
    wait_grant(k);
    total++;
    if (k !== 2 || mc_lsb_wr !== 1'b1 || cyc - last_done_cyc !== 3) begin
      bad++;
      $display("FAIL rb_if_next kind=%0d wr=%0b gap=%0d required 2/1/3", k, mc_lsb_wr, cyc - last_done_cyc);
    end
    finish_access(k, 3, 1'b1);
    lsb_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_rollback_st();
    int k;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h90; lsb_len = 3'd4;
    wait_grant(k);
    tick(); tick();
    rollback = 1'b1;
    tick();
    rollback = 1'b0;
    total++;
    if (dut.state_q !== BUSY_ST) begin
      bad++;
      $display("FAIL rb_st_state state=%0d required BUSY_ST", dut.state_q);
    end
    finish_access(k, 2, 1'b1);
    lsb_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_store();
    int k;
    int seen;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'hA0; lsb_len = 3'd2;
    wait_grant(k);
    #2 rst = 1'b0;
    #1;
    total++;
    if (mc_lsb_en !== 1'b0 || mc_lsb_addr !== 32'h0 || mc_lsb_len !== 3'd0 || mc_lsb_wr !== 1'b0) begin
      bad++;
      $display("FAIL async_reset en=%0b addr=%h len=%0d wr=%0b required all 0", mc_lsb_en, mc_lsb_addr, mc_lsb_len, mc_lsb_wr);
    end
    lsb_req = 1'b0;
    tick(); tick();
    rst = 1'b1;
    seen = 0;
    repeat (6) begin
      tick();
      if (lsb_done || if_done || mc_lsb_en || mc_if_en) seen++;
    end
    total++;
    if (seen !== 0 || dut.state_q !== IDLE) begin
      bad++;
      $display("FAIL post_reset events=%0d state=%0d required 0/IDLE", seen, dut.state_q);
    end
  endtask

  task automatic test_rdy();
    int k;
    int seen;
    int resume;
    rdy = 1'b0;
    if_req = 1'b1;  if_pc = 32'h700;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'hB0; lsb_len = 3'd1;
    seen = 0;
    repeat (5) begin
      tick();
      if (mc_if_en || mc_lsb_en) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL rdy_freeze en_count=%0d required=0", seen);
    end
    rdy = 1'b1;
    resume = cyc;
    wait_grant(k);
    total++;
    if (k !== 2 || cyc - resume !== 1 || mc_lsb_addr !== 32'hB0) begin
      bad++;
      $display("FAIL rdy_resume kind=%0d delay=%0d addr=%h required 2/1/000000b0", k, cyc - resume, mc_lsb_addr);
    end
    finish_access(k, 2, 1'b1);
    lsb_req = 1'b0;
    wait_grant(k);
    total++;
    if (k !== 1 || mc_if_pc !== 32'h700) begin
      bad++;
      $display("FAIL rdy_fetch kind=%0d pc=%h required 1/00000700", k, mc_if_pc);
    end
    finish_access(k, 2, 1'b1);
    if_req = 1'b0;
    repeat (2) tick();
  endtask

  // Reference: LSB wins unless fetch is pending and LIMIT LSB grants already went by it.
  task automatic test_random();
    int k;
    int exp_k;
    int streak;
    int sel;
    bit if_pend;
    bit lsb_pend;
    streak = 0;
    if_pend = 0;
    lsb_pend = 0;
    for (int n = 0; n < 60; n++) begin
      if (!if_pend && $urandom_range(0, 1) == 1) begin
        if_pend = 1;
        if_req = 1'b1;
        if_pc = $urandom & 32'hFFFF_FFFC;
      end
      if (!lsb_pend && ($urandom_range(0, 3) != 0 || !if_pend)) begin
        lsb_pend = 1;
        lsb_req = 1'b1;
        lsb_wr = 1'($urandom_range(0, 1));
        lsb_addr = $urandom;
        sel = $urandom_range(0, 2);
        lsb_len = (sel == 0) ? 3'd1 : (sel == 1) ? 3'd2 : 3'd4;
      end
      exp_k = (lsb_pend && (!if_pend || streak < LIMIT)) ? 2 : 1;
      wait_grant(k);
      total++;
      if (k !== exp_k) begin
        bad++;
        $display("FAIL rand_kind n=%0d got=%0d required=%0d streak=%0d", n, k, exp_k, streak);
      end
      total++;
      if (k == 2 && (mc_lsb_addr !== lsb_addr || mc_lsb_len !== lsb_len || mc_lsb_wr !== lsb_wr)) begin
        bad++;
        $display("FAIL rand_lsb_fields addr=%h/%h len=%0d/%0d wr=%0b/%0b", mc_lsb_addr, lsb_addr, mc_lsb_len, lsb_len, mc_lsb_wr, lsb_wr);
      end else if (k == 1 && mc_if_pc !== if_pc) begin
        bad++;
        $display("FAIL rand_pc got=%h required=%h", mc_if_pc, if_pc);
      end
      if (k == 2 && if_pend) streak = (streak < 15) ? streak + 1 : 15;
      if (k == 1) streak = 0;
      finish_access(k, $urandom_range(1, 6), 1'b1);
      if (k == 1) begin
        if_pend = 0;
        if_req = 1'b0;
      end else if (k == 2) begin
        lsb_pend = 0;
        lsb_req = 1'b0;
      end
      if (k == 0) break;
    end
    if_req = 1'b0;
    lsb_req = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_simultaneous();
    test_starvation();
    test_rollback_ld();
    test_rollback_if();
    test_rollback_st();
    test_reset_mid_store();
    test_rdy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
